// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch PC controller and its branch target buffer:
// counter encoding, BTB entry layout and saturating counter helpers.
package pc_fetch_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Widest address the entry layout supports; narrower builds zero-extend.
  localparam int unsigned MAX_XLEN = 64;

  typedef struct packed {
    logic                valid;
    logic [MAX_XLEN-1:0] tag;
    logic [MAX_XLEN-1:0] target;
    logic [1:0]          ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    if (c == ST) begin
      return ST;
    end else begin
      return c + 2'd1;
    end
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    if (c == SNT) begin
      return SNT;
    end else begin
      return c - 2'd1;
    end
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// training on resolved branches at the clock edge (reads see pre-update state).
module btb
  import pc_fetch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_lookup_pc,
  input  logic            i_update_valid,
  input  logic [XLEN-1:0] i_update_pc,
  input  logic [XLEN-1:0] i_update_target,
  input  logic            i_update_taken,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX - 2;

  btb_entry_t r_mem [BTB_DEPTH];

  logic [IDX-1:0]      w_lk_idx;
  logic [MAX_XLEN-1:0] w_lk_tag;
  btb_entry_t          w_lk_entry;
  logic                w_lk_hit;

  logic [IDX-1:0]      w_up_idx;
  logic [MAX_XLEN-1:0] w_up_tag;
  logic [MAX_XLEN-1:0] w_up_tgt;
  btb_entry_t          w_up_entry;
  logic                w_up_hit;
  btb_entry_t          w_up_next;
  logic                w_up_we;

  assign w_lk_idx   = i_lookup_pc[IDX+1:2];
  assign w_lk_tag   = MAX_XLEN'(i_lookup_pc[XLEN-1:IDX+2]);
  assign w_lk_entry = r_mem[w_lk_idx];
  assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

  // Prediction outputs; target is forced to zero when not predicting taken.
  always_comb begin
    o_pred_taken  = w_lk_hit && w_lk_entry.ctr[1];
    if (o_pred_taken) begin
      o_pred_target = {w_lk_entry.target[XLEN-1:2], 2'b00};
    end else begin
      o_pred_target = {XLEN{1'b0}};
    end
  end

  assign w_up_idx   = i_update_pc[IDX+1:2];
  assign w_up_tag   = MAX_XLEN'(i_update_pc[XLEN-1:IDX+2]);
  // Targets are stored word-aligned so the fetch PC never picks up low bits.
  assign w_up_tgt   = MAX_XLEN'({i_update_target[XLEN-1:2], 2'b00});
  assign w_up_entry = r_mem[w_up_idx];
  assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

  // Training: hysteresis on hits, allocate as weakly-taken on taken misses.
  always_comb begin
    w_up_next = w_up_entry;
    w_up_we   = 1'b0;
    if (i_update_valid) begin
      if (w_up_hit) begin
        w_up_we = 1'b1;
        if (i_update_taken) begin
          w_up_next.ctr    = sat_inc(w_up_entry.ctr);
          w_up_next.target = w_up_tgt;
        end else begin
          w_up_next.ctr    = sat_dec(w_up_entry.ctr);
          w_up_next.target = w_up_entry.target;
        end
      end else if (i_update_taken) begin
        w_up_we          = 1'b1;
        w_up_next.valid  = 1'b1;
        w_up_next.tag    = w_up_tag;
        w_up_next.target = w_up_tgt;
        w_up_next.ctr    = WT;
      end else begin
        w_up_we = 1'b0;
      end
    end else begin
      w_up_we = 1'b0;
    end
  end

  // Entry storage with synchronous clear of the whole table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_mem[i].valid  <= 1'b0;
        r_mem[i].tag    <= {MAX_XLEN{1'b0}};
        r_mem[i].target <= {MAX_XLEN{1'b0}};
        r_mem[i].ctr    <= WNT;
      end
    end else if (w_up_we) begin
      r_mem[w_up_idx] <= w_up_next;
    end
  end

  if (TAG_W < 1) begin : g_bad_cfg
    $error("btb: XLEN too small for BTB_DEPTH");
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register and next-PC selection: reset, redirect, stall, BTB
// prediction, then sequential fetch, in that priority order.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

  btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk             (clk),
    .rst             (rst),
    .i_lookup_pc     (r_pc),
    .i_update_valid  (update_valid),
    .i_update_pc     (update_pc),
    .i_update_target (update_target),
    .i_update_taken  (update_taken),
    .o_pred_taken    (w_pred_taken),
    .o_pred_target   (w_pred_target)
  );

  // Wraps modulo 2^XLEN by construction.
  assign w_pc_plus4 = r_pc + {{(XLEN-3){1'b0}}, 3'b100};

  // Next-PC priority below reset, which is applied in the register.
  always_comb begin
    if (redirect_valid) begin
      w_next_pc = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (stall) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_target;
    end else begin
      w_next_pc = w_pc_plus4;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= {RESET_PC[XLEN-1:2], 2'b00};
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign pred_taken  = w_pred_taken;
  assign pred_target = w_pred_target;

  if (XLEN < 8) begin : g_bad_xlen
    $error("pc_fetch_ctrl: XLEN must be at least 8");
  end

endmodule
